// File: rtl/pwm_timer_core_if.sv
// Bundles the control and status signals of the PWM timer core.
// The master side drives configuration and strobes; the slave side is the core.
interface pwm_timer_core_if #(
   parameter int unsigned CW  = 16,
   parameter int unsigned PSW = 8
);
   logic           en;
   logic [CW-1:0]  pr;
   logic [CW-1:0]  duty_in;
   logic           duty_wr;
   logic [PSW-1:0] presc;
   logic           oneshot;
   logic           start;
   logic           irq_clr;
   logic [CW-1:0]  cnt;
   logic           pwm_out;
   logic           busy;
   logic           irq;

   modport master (
      output en, pr, duty_in, duty_wr, presc, oneshot, start, irq_clr,
      input  cnt, pwm_out, busy, irq
   );

   modport slave (
      input  en, pr, duty_in, duty_wr, presc, oneshot, start, irq_clr,
      output cnt, pwm_out, busy, irq
   );
endinterface

// File: rtl/pwm_timer_core.sv
// Timer/PWM engine: prescaler, up-counter and shadowed period/duty registers.
// Shadows reload only at start or at a period wrap so the waveform never glitches.
module pwm_timer_core #(
   parameter int unsigned CW  = 16,
   parameter int unsigned PSW = 8
) (
   input logic              clk,
   input logic              rst,
   pwm_timer_core_if.slave  bus
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   state_e         state_q;
   logic [CW-1:0]  cnt_q;
   logic [CW-1:0]  per_sh_q;
   logic [CW-1:0]  duty_sh_q;
   logic [CW-1:0]  duty_pend_q;
   logic [PSW-1:0] pc_q;
   logic [PSW-1:0] psc_sh_q;
   logic           pwm_q;
   logic           irq_q;

   logic           running;
   logic           tick;
   logic           wrap;

   // Prescaler tick and period-wrap decode; nothing advances while disabled.
   always_comb begin
      running = bus.en && (state_q == StRun);
      tick    = running && (pc_q == psc_sh_q);
      wrap    = tick && (cnt_q == per_sh_q);
   end

   // Single state machine holding counter, shadows, PWM output and interrupt.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         pc_q        <= '0;
         per_sh_q    <= '1;
         duty_sh_q   <= '0;
         duty_pend_q <= '0;
         psc_sh_q    <= '0;
         pwm_q       <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         // Pending duty is captured in any state and only consumed at load points.
         if (bus.duty_wr) begin
            duty_pend_q <= bus.duty_in;
         end

         // Compare against the current counter: one clock of latency behind cnt.
         pwm_q <= (state_q == StRun) && (cnt_q < duty_sh_q);

         // A wrap in the same cycle as a clear keeps the interrupt set.
         if (wrap) begin
            irq_q <= 1'b1;
         end else if (bus.irq_clr) begin
            irq_q <= 1'b0;
         end

         if (!bus.en) begin
            // Disable parks the engine but keeps shadows, pending duty and irq.
            state_q <= StIdle;
            cnt_q   <= '0;
            pc_q    <= '0;
         end else begin
            unique case (state_q)
               StIdle, StDone: begin
                  if (bus.start) begin
                     per_sh_q  <= bus.pr;
                     duty_sh_q <= duty_pend_q;
                     psc_sh_q  <= bus.presc;
                     cnt_q     <= '0;
                     pc_q      <= '0;
                     state_q   <= StRun;
                  end
               end
               StRun: begin
                  if (tick) begin
                     pc_q <= '0;
                     if (cnt_q == per_sh_q) begin
                        // Period boundary: reload shadows from the live inputs.
                        cnt_q     <= '0;
                        per_sh_q  <= bus.pr;
                        duty_sh_q <= duty_pend_q;
                        if (bus.oneshot) begin
                           state_q <= StDone;
                        end
                     end else begin
                        cnt_q <= cnt_q + CW'(1);
                     end
                  end else begin
                     pc_q <= pc_q + PSW'(1);
                  end
               end
               default: begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
                  pc_q    <= '0;
               end
            endcase
         end
      end
   end

   // Status outputs come straight from registers.
   always_comb begin
      bus.cnt     = cnt_q;
      bus.pwm_out = pwm_q;
      bus.busy    = (state_q == StRun);
      bus.irq     = irq_q;
   end

endmodule

// File: tb/tb_pwm_timer_core.sv
// Directed bench for pwm_timer_core with hand-computed expected values.
module tb_pwm_timer_core;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int passed = 0;
   int fails  = 0;
   int total  = 0;

   pwm_timer_core_if #(.CW(16), .PSW(8)) bus ();

   pwm_timer_core #(.CW(16), .PSW(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic stepc(input string tag, input logic [15:0] ecnt, input logic epwm,
                        input logic eirq);
      step();
      chk({tag, " cnt"}, 32'(bus.cnt), 32'(ecnt));
      chk({tag, " pwm"}, 32'(bus.pwm_out), 32'(epwm));
      chk({tag, " irq"}, 32'(bus.irq), 32'(eirq));
   endtask

   initial begin
      bus.en = 1'b0; bus.pr = '0; bus.duty_in = '0; bus.duty_wr = 1'b0;
      bus.presc = '0; bus.oneshot = 1'b0; bus.start = 1'b0; bus.irq_clr = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst cnt", 32'(bus.cnt), 32'd0);
      chk("rst pwm", 32'(bus.pwm_out), 32'd0);
      chk("rst irq", 32'(bus.irq), 32'd0);
      chk("rst busy", 32'(bus.busy), 32'd0);
      rst = 1'b0;

      // Basic PWM: pr=4, duty=2, presc=0
      bus.en = 1'b1; bus.pr = 16'd4; bus.presc = 8'd0; bus.duty_in = 16'd2; bus.duty_wr = 1'b1;
      step();
      bus.duty_wr = 1'b0; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("basic busy", 32'(bus.busy), 32'd1);
      chk("basic cnt0", 32'(bus.cnt), 32'd0);
      stepc("basic1", 16'd1, 1'b1, 1'b0);
      stepc("basic2", 16'd2, 1'b1, 1'b0);
      stepc("basic3", 16'd3, 1'b0, 1'b0);
      stepc("basic4", 16'd4, 1'b0, 1'b0);
      stepc("basic5", 16'd0, 1'b0, 1'b1);
      stepc("basic6", 16'd1, 1'b1, 1'b1);
      stepc("basic7", 16'd2, 1'b1, 1'b1);

      // irq_clr alone, then irq_clr coinciding with a wrap
      bus.irq_clr = 1'b1;
      stepc("clr alone", 16'd3, 1'b0, 1'b0);
      bus.irq_clr = 1'b0;
      stepc("pre wrap", 16'd4, 1'b0, 1'b0);
      bus.irq_clr = 1'b1;
      stepc("clr on wrap", 16'd0, 1'b0, 1'b1);
      bus.irq_clr = 1'b0;

      // en=0 mid-run: idle next clock, irq kept
      bus.en = 1'b0;
      step();
      chk("dis busy", 32'(bus.busy), 32'd0);
      chk("dis cnt", 32'(bus.cnt), 32'd0);
      chk("dis irq", 32'(bus.irq), 32'd1);
      step();
      chk("dis pwm", 32'(bus.pwm_out), 32'd0);
      bus.en = 1'b1;

      // Prescaler: presc=2, pr=1, duty=1
      bus.presc = 8'd2; bus.pr = 16'd1; bus.duty_in = 16'd1; bus.duty_wr = 1'b1; bus.irq_clr = 1'b1;
      step();
      bus.duty_wr = 1'b0; bus.irq_clr = 1'b0; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      stepc("psc1", 16'd0, 1'b1, 1'b0);
      stepc("psc2", 16'd0, 1'b1, 1'b0);
      stepc("psc3", 16'd1, 1'b1, 1'b0);
      stepc("psc4", 16'd1, 1'b0, 1'b0);
      stepc("psc5", 16'd1, 1'b0, 1'b0);
      stepc("psc6", 16'd0, 1'b0, 1'b1);
      stepc("psc7", 16'd0, 1'b1, 1'b1);
      stepc("psc8", 16'd0, 1'b1, 1'b1);
      stepc("psc9", 16'd1, 1'b1, 1'b1);

      // Shadow update: pr=9 duty=5, at cnt=3 write duty=8 and pr=4
      bus.en = 1'b0;
      step();
      bus.en = 1'b1; bus.pr = 16'd9; bus.presc = 8'd0; bus.duty_in = 16'd5; bus.duty_wr = 1'b1;
      step();
      bus.duty_wr = 1'b0; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      stepc("shd1", 16'd1, 1'b1, 1'b1);
      stepc("shd2", 16'd2, 1'b1, 1'b1);
      stepc("shd3", 16'd3, 1'b1, 1'b1);
      bus.duty_in = 16'd8; bus.duty_wr = 1'b1; bus.pr = 16'd4;
      stepc("shd4", 16'd4, 1'b1, 1'b1);
      bus.duty_wr = 1'b0;
      stepc("shd5", 16'd5, 1'b1, 1'b1);
      stepc("shd6", 16'd6, 1'b0, 1'b1);
      stepc("shd7", 16'd7, 1'b0, 1'b1);
      stepc("shd8", 16'd8, 1'b0, 1'b1);
      stepc("shd9", 16'd9, 1'b0, 1'b1);
      stepc("shd10", 16'd0, 1'b0, 1'b1);
      stepc("shd11", 16'd1, 1'b1, 1'b1);
      stepc("shd12", 16'd2, 1'b1, 1'b1);
      stepc("shd13", 16'd3, 1'b1, 1'b1);
      stepc("shd14", 16'd4, 1'b1, 1'b1);
      stepc("shd15", 16'd0, 1'b1, 1'b1);

      // One-shot: pr=3, duty pending is 8
      bus.en = 1'b0; bus.irq_clr = 1'b1;
      step();
      bus.en = 1'b1; bus.irq_clr = 1'b0; bus.oneshot = 1'b1; bus.pr = 16'd3; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("os busy0", 32'(bus.busy), 32'd1);
      stepc("os1", 16'd1, 1'b1, 1'b0);
      stepc("os2", 16'd2, 1'b1, 1'b0);
      stepc("os3", 16'd3, 1'b1, 1'b0);
      chk("os busy3", 32'(bus.busy), 32'd1);
      stepc("os4", 16'd0, 1'b1, 1'b1);
      chk("os done busy", 32'(bus.busy), 32'd0);
      stepc("os5", 16'd0, 1'b0, 1'b1);
      chk("os done busy2", 32'(bus.busy), 32'd0);
      bus.irq_clr = 1'b1;
      step();
      chk("os clr irq", 32'(bus.irq), 32'd0);
      bus.irq_clr = 1'b0; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("os2 busy", 32'(bus.busy), 32'd1);
      repeat (3) step();
      chk("os2 busy3", 32'(bus.busy), 32'd1);
      step();
      chk("os2 done busy", 32'(bus.busy), 32'd0);
      chk("os2 irq", 32'(bus.irq), 32'd1);

      // duty=0: pwm never high
      bus.oneshot = 1'b0; bus.pr = 16'd2; bus.duty_in = 16'd0; bus.duty_wr = 1'b1;
      step();
      bus.duty_wr = 1'b0; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      stepc("d0 1", 16'd1, 1'b0, 1'b1);
      stepc("d0 2", 16'd2, 1'b0, 1'b1);
      stepc("d0 3", 16'd0, 1'b0, 1'b1);
      stepc("d0 4", 16'd1, 1'b0, 1'b1);
      stepc("d0 5", 16'd2, 1'b0, 1'b1);
      stepc("d0 6", 16'd0, 1'b0, 1'b1);

      // pr=0: wrap every clock, so irq holds against a continuous clear
      bus.en = 1'b0;
      step();
      bus.en = 1'b1; bus.pr = 16'd0; bus.irq_clr = 1'b1;
      step();
      chk("pr0 cleared", 32'(bus.irq), 32'd0);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("pr0 start irq", 32'(bus.irq), 32'd0);
      stepc("pr0 1", 16'd0, 1'b0, 1'b1);
      stepc("pr0 2", 16'd0, 1'b0, 1'b1);
      stepc("pr0 3", 16'd0, 1'b0, 1'b1);
      stepc("pr0 4", 16'd0, 1'b0, 1'b1);
      bus.irq_clr = 1'b0;

      // Asynchronous reset at cnt=7
      bus.en = 1'b0;
      step();
      bus.en = 1'b1; bus.pr = 16'd9; bus.duty_in = 16'd9; bus.duty_wr = 1'b1;
      step();
      bus.duty_wr = 1'b0; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (7) step();
      chk("pre rst cnt", 32'(bus.cnt), 32'd7);
      chk("pre rst pwm", 32'(bus.pwm_out), 32'd1);
      chk("pre rst irq", 32'(bus.irq), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async cnt", 32'(bus.cnt), 32'd0);
      chk("async pwm", 32'(bus.pwm_out), 32'd0);
      chk("async irq", 32'(bus.irq), 32'd0);
      chk("async busy", 32'(bus.busy), 32'd0);
      #5 rst = 1'b0;
      step();
      step();
      chk("post rst busy", 32'(bus.busy), 32'd0);
      chk("post rst cnt", 32'(bus.cnt), 32'd0);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("restart busy", 32'(bus.busy), 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pwm_timer_core.md
Name: pwm_timer_core

Overview:
- Timer/PWM engine that consumes the 16-bit period value from the period register stage (PR, resets to 16'hFFFF) and produces a PWM waveform plus a period-wrap interrupt.
- Contains a prescaler, an up-counter, and double-buffered (shadow) period and duty registers that update only at period boundaries, so waveforms never glitch.
- Supports continuous and one-shot operation.
- Sits between the timer's memory-mapped register stages and the SoC interrupt/GPIO logic.

Parameters:
- CW, 16, counter/period/duty width.
- PSW, 8, prescaler width.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- en  input  1  block enable; low forces IDLE synchronously
- pr  input  CW  period value from the period register; counter counts 0..pr
- duty_in  input  CW  compare value
- duty_wr  input  1  one-cycle strobe; captures duty_in into the pending duty register
- presc  input  PSW  prescale divisor minus 1; tick every presc+1 clocks
- oneshot  input  1  1 = stop after one period, 0 = continuous
- start  input  1  one-cycle strobe; starts counting
- irq_clr  input  1  clears irq
- cnt  output  CW  current counter value
- pwm_out  output  1  PWM output, registered
- busy  output  1  high in RUN
- irq  output  1  sticky period-wrap interrupt

Behaviour:
- Reset values:
  - state = IDLE; cnt = 0; pwm_out = 0; irq = 0; busy = 0
  - prescaler count pc = 0
  - per_sh = all ones; duty_sh = 0; duty_pend = 0; psc_sh = 0
- States: IDLE, RUN, DONE. busy = (state == RUN).
- duty_wr: duty_pend <= duty_in in any state, including IDLE. Has no effect on duty_sh until the next load point.
- Load points:
  - start accepted (IDLE or DONE, en = 1): per_sh <= pr, duty_sh <= duty_pend, psc_sh <= presc, cnt <= 0, pc <= 0, state <= RUN.
  - start while in RUN is ignored.
- Prescaler (RUN only):
  - tick = (pc == psc_sh).
  - On tick, pc <= 0; otherwise pc <= pc + 1.
  - presc = 0 gives a tick every clock.
- Counter (RUN, on tick):
  - If cnt == per_sh: wrap event. cnt <= 0; per_sh <= pr; duty_sh <= duty_pend; irq <= 1. If oneshot = 1, state <= DONE.
  - Otherwise cnt <= cnt + 1. Unsigned arithmetic, no overflow possible because cnt never exceeds per_sh.
  - Period = (per_sh + 1) * (psc_sh + 1) clocks.
- pwm_out: updated every clock as pwm_out <= (state == RUN) && (cnt < duty_sh), i.e. one clock of latency after cnt.
  - duty_sh = 0: always low.
  - duty_sh > per_sh: always high while RUN.
- per_sh = 0: cnt stays 0; a wrap occurs on every tick.
- DONE: cnt holds 0, pwm_out = 0, irq is retained. start re-arms.
- en = 0 (synchronous, any state): state <= IDLE, cnt <= 0, pc <= 0. Shadows, duty_pend and irq are retained. start is ignored while en = 0.
- irq: set on wrap, cleared by irq_clr. If set and clear happen in the same cycle, set wins.
- pr changes mid-period take effect only at the next wrap or start.
- rst asserted mid-operation: all registers return to reset values immediately (asynchronous). Operation resumes only after a new start.

Test Plan:
- Basic PWM:
  - Stimulus: presc = 0, pr = 4, duty_wr with 2, oneshot = 0, start.
  - Required response: cnt sequence 0,1,2,3,4,0...; pwm_out high 2 of every 5 clocks (lagging cnt by 1); irq rises 5 clocks after the start edge; busy = 1.
- Prescaler:
  - Stimulus: presc = 2, pr = 1, duty = 1.
  - Required response: cnt changes every 3 clocks; wrap and irq every 6 clocks; pwm_out high 3 of 6.
- Shadow update:
  - Stimulus: running with pr = 9, duty = 5; at cnt = 3 write duty = 8 and change pr to 4.
  - Required response: current period keeps duty 5 and length 10; next period has length 5 with pwm_out always high (8 > 4).
- One-shot:
  - Stimulus: oneshot = 1, pr = 3, presc = 0, start.
  - Required response: 4 clocks in RUN, then DONE with busy = 0, pwm_out = 0, irq = 1; a second start gives one more period.
- Boundaries and interrupt:
  - duty = 0 -> pwm_out never high.
  - pr = 0 -> irq set every clock.
  - irq_clr asserted in the same cycle as a wrap -> irq stays 1.
  - irq_clr alone -> irq = 0 next clock.
- Reset and enable:
  - Stimulus: assert rst asynchronously at cnt = 7.
  - Required response: cnt = 0, pwm_out = 0, irq = 0 immediately; busy stays 0 until start.
  - Stimulus: en = 0 mid-run.
  - Required response: IDLE next clock with irq preserved.
